// File: rtl/adder_share_arbiter.sv
// One N-bit adder shared round-robin among NREQ valid/ready requesters.
// The result, carry and requester ID are held in a one-deep registered response slot.
module adder_share_arbiter #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ*N-1:0] req_x_i,
    input  logic [NREQ*N-1:0] req_y_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic              rsp_valid_o,
    output logic [N-1:0]      rsp_data_o,
    output logic              rsp_carry_o,
    output logic [IDW-1:0]    rsp_id_o,
    input  logic              rsp_ready_i
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state_q;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  win_id;
    logic [NREQ-1:0] gnt;
    logic            found;
    logic            can_accept;
    logic            xfer;
    logic [N-1:0]    x_sel, y_sel;
    logic [N:0]      sum;
    logic [N-1:0]    rsp_data_q;
    logic            rsp_carry_q;
    logic [IDW-1:0]  rsp_id_q;

    // Rotating scan from ptr_q; the first requester found wins.
    always_comb begin
        int j;
        gnt    = '0;
        win_id = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req_valid_i[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                win_id = IDW'(j);
            end
        end
    end

    assign can_accept  = (state_q == EMPTY) || rsp_ready_i;
    assign req_ready_o = rst ? '0 : (gnt & {NREQ{can_accept}});
    assign xfer        = found && can_accept && !rst;

    assign ptr_d = (int'(win_id) == NREQ - 1) ? '0 : win_id + 1'b1;

    // Operands are sampled only at acceptance, so the mux follows the winner.
    assign x_sel = req_x_i[int'(win_id)*N +: N];
    assign y_sel = req_y_i[int'(win_id)*N +: N];
    assign sum   = {1'b0, x_sel} + {1'b0, y_sel};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (xfer) begin
                        state_q                   <= FULL;
                        {rsp_carry_q, rsp_data_q} <= sum;
                        rsp_id_q                  <= win_id;
                        ptr_q                     <= ptr_d;
                    end
                end
                FULL: begin
                    if (xfer) begin
                        {rsp_carry_q, rsp_data_q} <= sum;
                        rsp_id_q                  <= win_id;
                        ptr_q                     <= ptr_d;
                    end else if (rsp_ready_i) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_data_o  = rsp_data_q;
    assign rsp_carry_o = rsp_carry_q;
    assign rsp_id_o    = rsp_id_q;

    a_onehot_ready: assert property (@(posedge clk) $onehot0(req_ready_o));

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized and directed bench for adder_share_arbiter against a cycle-level
// reference model of the arbiter and its response slot.
module tb_adder_share_arbiter;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_x, req_y;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [N-1:0]      rsp_data;
    logic              rsp_carry;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    logic         m_valid;
    logic [N-1:0] m_data;
    logic         m_carry;
    int           m_id;
    int           m_ptr;

    adder_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_x_i(req_x), .req_y_i(req_y),
        .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_carry_o(rsp_carry),
        .rsp_id_o(rsp_id), .rsp_ready_i(rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [N+IDW+1:0] rsp_act = {rsp_valid, rsp_carry, rsp_id, rsp_data};

    function automatic logic [N+IDW+1:0] exp_rsp();
        return {m_valid, m_carry, IDW'(m_id), m_data};
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] r;
        r = '0;
        if (rst || (m_valid && !rsp_ready)) return r;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) begin
                r[(m_ptr + k) % NREQ] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic set_req(input int i, input logic [N-1:0] x, input logic [N-1:0] y);
        req_valid[i]     = 1'b1;
        req_x[i*N +: N]  = x;
        req_y[i*N +: N]  = y;
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic [NREQ-1:0] r;
        logic [N:0]      s;
        r = exp_ready();
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_carry = 1'b0; m_id = 0; m_ptr = 0;
        end else if (r != '0) begin
            for (int i = 0; i < NREQ; i++) begin
                if (r[i]) begin
                    s = {1'b0, req_x[i*N +: N]} + {1'b0, req_y[i*N +: N]};
                    m_carry = s[N];
                    m_data  = s[N-1:0];
                    m_id    = i;
                    m_valid = 1'b1;
                    m_ptr   = (i + 1) % NREQ;
                end
            end
        end else if (m_valid && rsp_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        req_x = '0; req_y = '0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++; $display("FAIL reset_ready: got %b want 0000", req_ready);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_act !== '0) begin
            miscompares++; $display("FAIL reset_rsp: got %h want 0", rsp_act);
        end
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 32'd5, 32'd7);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0001) begin
            miscompares++; $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_carry !== 1'b0 || rsp_id !== 2'd0) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%b d=%0d c=%b id=%0d want v=1 d=12 c=0 id=0",
                     rsp_valid, rsp_data, rsp_carry, rsp_id);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'd12) begin
            miscompares++; $display("FAIL single_drain: got v=%b d=%0d want v=0 d=12", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        set_req(0, 32'hFFFF_FFFF, 32'h0000_0002);
        tick();
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_data !== 32'h0000_0001 || rsp_carry !== 1'b1) begin
            miscompares++; $display("FAIL overflow: got d=%h c=%b want d=00000001 c=1", rsp_data, rsp_carry);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, N'(i), 32'd100);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== (4'b0001 << (c % 4))) begin
                miscompares++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, 4'b0001 << (c % 4));
            end
            if (c > 0) begin
                vectors++;
                if (rsp_valid !== 1'b1 || rsp_id !== IDW'((c - 1) % 4) || rsp_data !== 32'(100 + (c - 1) % 4)) begin
                    miscompares++;
                    $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d",
                             c, rsp_valid, rsp_id, rsp_data, (c - 1) % 4, 100 + (c - 1) % 4);
                end
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [N+IDW+1:0] held;
        do_reset();
        set_req(2, 32'd20, 32'd22);
        tick();
        req_valid = '0; rsp_ready = 1'b0;
        set_req(1, 32'd1, 32'd1);
        set_req(3, 32'd3, 32'd3);
        held = rsp_act;
        vectors++;
        if (held !== {1'b1, 1'b0, 2'd2, 32'd42}) begin
            miscompares++; $display("FAIL bp_first: got %h want %h", held, {1'b1, 1'b0, 2'd2, 32'd42});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (req_ready !== 4'b0000 || rsp_act !== exp_rsp()) begin
                miscompares++; $display("FAIL bp_stall[%0d]: ready=%b rsp=%h want 0000 %h", c, req_ready, rsp_act, exp_rsp());
            end
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++; $display("FAIL bp_release: got %b want 1000", req_ready);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010 || rsp_id !== 2'd3 || rsp_data !== 32'd6) begin
            miscompares++; $display("FAIL bp_next: ready=%b id=%0d d=%0d want 0010 3 6", req_ready, rsp_id, rsp_data);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 32'd9, 32'd9);
        tick();
        req_valid = '0; rsp_ready = 1'b0;
        set_req(1, 32'd50, 32'd60);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0000) begin
            miscompares++; $display("FAIL rstmid_ready: got %b want 0000", req_ready);
        end
        tick();
        rst = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL rstmid_after: v=%b ready=%b want 0 0010", rsp_valid, req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'd110) begin
            miscompares++; $display("FAIL rstmid_regrant: v=%b id=%0d d=%0d want 1 1 110", rsp_valid, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        set_req(1, 32'd0, 32'd0);
        tick();
        req_valid = '0;
        set_req(1, 32'd11, 32'd0);
        set_req(2, 32'd22, 32'd0);
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0100) begin
            miscompares++; $display("FAIL ptr_first: got %b want 0100", req_ready);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (req_ready !== 4'b0010) begin
            miscompares++; $display("FAIL ptr_second: got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                req_x[i*N +: N] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | N'($urandom_range(0, 15)) : $urandom;
                req_y[i*N +: N] = $urandom;
            end
            @(negedge clk);
            vectors++;
            if (req_ready !== exp_ready() || rsp_act !== exp_rsp()) begin
                miscompares++;
                $display("FAIL random[%0d]: ready=%b rsp=%h want %b %h", c, req_ready, rsp_act, exp_ready(), exp_rsp());
            end
            tick();
        end
        rst = 1'b0; req_valid = '0;
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_carry = 1'b0; m_id = 0; m_ptr = 0;
        rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b1;
        #1;
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_ptr_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one N-bit adder between NREQ requesters (e.g. PC-increment, branch-target and load/store address units in a future multi-cycle core).
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- The result, carry and requester ID go to a one-deep registered response slot with its own valid/ready handshake.
- Throughput is one add per cycle when the response side never stalls.

Parameters:
- N, 32, operand/result width in bits.
- NREQ, 4, number of requesters; must be ≥2.
- IDW, $clog2(NREQ), width of requester ID.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents operands.
- req_x  input  NREQ*N  operand X of requester i at bits [i*N +: N].
- req_y  input  NREQ*N  operand Y of requester i at bits [i*N +: N].
- req_ready  output  NREQ  bit i: requester i's operands are accepted this cycle.
- rsp_valid  output  1  response slot holds a result.
- rsp_data  output  N  (X+Y) mod 2^N.
- rsp_carry  output  1  carry out of bit N-1 (unsigned overflow).
- rsp_id  output  IDW  index of the requester that produced rsp_data.
- rsp_ready  input  1  consumer takes the response this cycle.

Behaviour:
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_id=0, priority pointer ptr=0.
  - req_ready is forced to all zeros combinationally while rst=1.
  - Reset mid-transfer drops the pending response; any requester handshake in that cycle is not accepted.
- FSM, two states:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY | (FULL & rsp_ready).
- Arbitration (combinational):
  - Scan req_valid starting at index ptr, wrapping NREQ-1→0. The first set bit wins (gnt, one-hot).
  - req_ready = gnt & {NREQ{can_accept}}. At most one bit is set.
  - req_ready depends only on req_valid, ptr, state and rsp_ready; it never depends on req_x or req_y.
- Transfer: a transfer happens when req_valid[w] & req_ready[w] for winner w. At the next edge:
  - {rsp_carry, rsp_data} ← zero-extended X + Y from a single (N+1)-bit add of requester w's operands.
  - rsp_id ← w; rsp_valid ← 1 (state FULL).
  - ptr ← (w+1) mod NREQ.
  - Latency is 1 cycle from acceptance to rsp_valid.
- Drain: FULL & rsp_ready with no new transfer → EMPTY at the next edge. rsp_data, rsp_carry and rsp_id keep their last values.
- Simultaneous drain and accept: FULL & rsp_ready & transfer → stays FULL with the new result (back-to-back, no bubble).
- Stall: FULL & !rsp_ready → all req_ready=0. rsp_* hold stable until taken.
- No request: ptr is unchanged and no req_ready is asserted.
- Requester rules:
  - A requester holding req_valid must keep req_x and req_y stable until accepted.
  - The block does not require this for correctness, because operands are sampled only at acceptance.
- Fairness: a continuously requesting requester waits at most NREQ-1 grants.
- Wrap-around: sum wraps modulo 2^N and the carry flag reports the overflow. Signed overflow is not reported.

Test Plan:
1. Reset, then requester 0 alone sends X=5, Y=7, rsp_ready=1.
   - req_ready=0001 that cycle.
   - Next cycle: rsp_valid=1, rsp_data=12, rsp_carry=0, rsp_id=0.
   - Following cycle: rsp_valid=0.
2. Overflow: X=32'hFFFF_FFFF, Y=32'h0000_0002.
   - rsp_data=32'h0000_0001, rsp_carry=1.
3. All four requesters valid every cycle, rsp_ready=1, requester i sends X=i, Y=100.
   - Grant order is 0,1,2,3,0,…, one per cycle.
   - rsp_id sequence 0,1,2,3 with rsp_data 100,101,102,103 and no idle cycles.
4. Backpressure: produce a result with id 2, hold rsp_ready=0 for 5 cycles while requesters 1 and 3 are valid.
   - req_ready=0 and rsp_* stable throughout.
   - Raising rsp_ready gives same-cycle acceptance of requester 3 (ptr=3), followed by requester 1.
5. Assert rst for one cycle while FULL and requester 1 is valid.
   - Next cycle: rsp_valid=0, ptr=0, no response for requester 1's pending operands.
   - After reset, requester 1 is re-granted.
6. Requesters 1 and 2 valid with ptr=2.
   - Requester 2 wins first, then ptr=3, then requester 1 wins.
